// File: rtl/axis_hdr_insert_p.sv
// axis_hdr_insert_p: AXI-Stream header inserter for any byte-multiple data width.
// A header of 0..DATA_BYTE_WD bytes is put in front of each packet. Every
// following beat is realigned through a carry register. When the shifted tail
// no longer fits in the last beat, one extra flush beat is emitted.
//
// Build option: define AXIS_HDR_SKID_EN to replace the single output register
// with a 2-entry output buffer. In that build ready_in is driven only from
// flops and has no combinational path from ready_out.
//
// state  | meaning
// IDLE   | waiting for a header handshake; data input closed
// STREAM | realigning input beats through the carry register
// FLUSH  | last input beat taken, tail bytes still in CR await output space
// DRAIN  | final beat of the packet queued, waiting for its last_out handshake
module axis_hdr_insert_p #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int HDR_CNT_WD   = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    valid_insert,
  output logic                    ready_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [HDR_CNT_WD-1:0]   hdr_bytes
);

  localparam int NB = DATA_BYTE_WD;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  // Mask with the top n byte lanes set (lane NB-1 is first on the wire).
  function automatic logic [NB-1:0] top_lanes(input int n);
    top_lanes = '0;
    for (int i = 0; i < NB; i++) begin
      top_lanes[i] = (i >= NB - n);
    end
  endfunction

  // Expand a byte-lane mask into a bit mask.
  function automatic logic [DATA_WD-1:0] lane_bits(input logic [NB-1:0] m);
    lane_bits = '0;
    for (int i = 0; i < NB; i++) begin
      lane_bits[8*i +: 8] = {8{m[i]}};
    end
  endfunction

  logic [1:0]            state_q, state_d;
  logic [HDR_CNT_WD-1:0] hlen_q, hlen_d;
  logic [HDR_CNT_WD-1:0] fcnt_q, fcnt_d;
  logic [DATA_WD-1:0]    cr_q, cr_d;

  int                    h_int;
  int                    k_int;
  int                    sum_int;
  int                    hins_int;
  logic [DATA_WD-1:0]    stream_data;

  logic                  can_load;
  logic                  in_fire;
  logic                  push;
  logic [DATA_WD-1:0]    beat_data;
  logic [NB-1:0]         beat_keep;
  logic                  beat_last;

  logic                  ov_int;
  logic [DATA_WD-1:0]    od_int;
  logic [NB-1:0]         ok_int;
  logic                  ol_int;

  assign ready_insert = rst_n && (state_q == S_IDLE);
  assign ready_in     = rst_n && (state_q == S_STREAM) && can_load;
  assign in_fire      = valid_in && ready_in;

  // Byte arithmetic for the current beat: header length, tail size, realigned data.
  always_comb begin
    h_int = int'(hlen_q);
    k_int = 0;
    for (int i = 0; i < NB; i++) begin
      k_int = k_int + (keep_in[i] ? 1 : 0);
    end
    sum_int     = h_int + k_int;
    hins_int    = (int'(hdr_bytes) > NB) ? NB : int'(hdr_bytes);
    stream_data = (cr_q << (8 * (NB - h_int))) | (data_in >> (8 * h_int));
  end

  // Next-state, carry update and the beat offered to the output stage.
  always_comb begin
    state_d   = state_q;
    hlen_d    = hlen_q;
    fcnt_d    = fcnt_q;
    cr_d      = cr_q;
    push      = 1'b0;
    beat_data = '0;
    beat_keep = '0;
    beat_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_insert && ready_insert) begin
          hlen_d  = HDR_CNT_WD'(hins_int);
          cr_d    = data_insert & lane_bits(~top_lanes(NB - hins_int));
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (in_fire) begin
          push      = 1'b1;
          cr_d      = data_in & lane_bits(~top_lanes(NB - h_int));
          beat_keep = (sum_int > NB) ? '1 : top_lanes(sum_int);
          beat_data = stream_data & lane_bits(beat_keep);
          beat_last = last_in && (sum_int <= NB);
          if (last_in) begin
            if (sum_int > NB) begin
              fcnt_d  = HDR_CNT_WD'(sum_int - NB);
              state_d = S_FLUSH;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_FLUSH: begin
        if (can_load) begin
          push      = 1'b1;
          beat_keep = top_lanes(int'(fcnt_q));
          beat_data = (cr_q << (8 * (NB - h_int))) & lane_bits(beat_keep);
          beat_last = 1'b1;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (valid_out && ready_out && last_out) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and carry registers; reset discards any packet in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hlen_q  <= '0;
      fcnt_q  <= '0;
      cr_q    <= '0;
    end else begin
      state_q <= state_d;
      hlen_q  <= hlen_d;
      fcnt_q  <= fcnt_d;
      cr_q    <= cr_d;
    end
  end

`ifdef AXIS_HDR_SKID_EN
  logic [DATA_WD-1:0] sk_data_q [2];
  logic [NB-1:0]      sk_keep_q [2];
  logic               sk_last_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         cnt_q;
  logic               pop;

  // Space is judged from the registered fill level only, so ready_out never
  // reaches ready_in combinationally; two entries keep full rate under stalls.
  assign can_load = (cnt_q != 2'd2);
  assign ov_int   = (cnt_q != 2'd0);
  assign od_int   = sk_data_q[rd_ptr_q];
  assign ok_int   = sk_keep_q[rd_ptr_q];
  assign ol_int   = sk_last_q[rd_ptr_q];
  assign pop      = ov_int && ready_out;

  // Two-entry output FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        sk_data_q[i] <= '0;
        sk_keep_q[i] <= '0;
        sk_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        sk_data_q[wr_ptr_q] <= beat_data;
        sk_keep_q[wr_ptr_q] <= beat_keep;
        sk_last_q[wr_ptr_q] <= beat_last;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
`else
  logic               out_valid_q;
  logic [DATA_WD-1:0] out_data_q;
  logic [NB-1:0]      out_keep_q;
  logic               out_last_q;

  assign can_load = !out_valid_q || ready_out;
  assign ov_int   = out_valid_q;
  assign od_int   = out_data_q;
  assign ok_int   = out_keep_q;
  assign ol_int   = out_last_q;

  // Single output register; held until the downstream handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (push) begin
      out_valid_q <= 1'b1;
      out_data_q  <= beat_data;
      out_keep_q  <= beat_keep;
      out_last_q  <= beat_last;
    end else if (ready_out) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  // Outputs read as idle for the whole time reset is held low.
  assign valid_out = rst_n && ov_int;
  assign data_out  = rst_n ? od_int : '0;
  assign keep_out  = rst_n ? ok_int : '0;
  assign last_out  = rst_n && ol_int;

endmodule

// File: tb/tb_axis_hdr_insert_p.sv
// Bench for axis_hdr_insert_p at DATA_WD=32: directed packets with constant
// expectations, then random packets against a byte-stream reference model.
module tb_axis_hdr_insert_p;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [DW-1:0] data_in = '0;
  logic [NB-1:0] keep_in = '0;
  logic          last_in = 1'b0;
  logic          valid_out;
  logic          ready_out = 1'b1;
  logic [DW-1:0] data_out;
  logic [NB-1:0] keep_out;
  logic          last_out;
  logic          valid_insert = 1'b0;
  logic          ready_insert;
  logic [DW-1:0] data_insert = '0;
  logic [CW-1:0] hdr_bytes = '0;

  int n_chk = 0;
  int n_err = 0;
  bit bp_en = 1'b0;
  bit mon_en = 1'b0;

  // expected output beats as {last, keep, data}
  logic [36:0] exp_q[$];
  logic [36:0] dir_q[$];

  axis_hdr_insert_p #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
    .keep_in(keep_in), .last_in(last_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .keep_out(keep_out), .last_out(last_out),
    .valid_insert(valid_insert), .ready_insert(ready_insert),
    .data_insert(data_insert), .hdr_bytes(hdr_bytes)
  );

  initial forever #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: output is the header bytes followed by the payload bytes,
  // cut into NB-byte top-aligned beats with zeroed unused lanes.
  task automatic model_pkt(input int h, input logic [31:0] hdr, input logic [7:0] pl[$]);
    logic [7:0] s[$];
    logic [31:0] d;
    logic [3:0] k;
    int heff;
    heff = (h > NB) ? NB : h;
    for (int i = heff - 1; i >= 0; i--) s.push_back(hdr[8*i +: 8]);
    foreach (pl[i]) s.push_back(pl[i]);
    for (int b = 0; b < s.size(); b += NB) begin
      d = '0;
      k = '0;
      for (int j = 0; j < NB; j++) begin
        if (b + j < s.size()) begin
          d[8*(NB-1-j) +: 8] = s[b+j];
          k[NB-1-j] = 1'b1;
        end
      end
      exp_q.push_back({(b + NB >= s.size()), k, d});
    end
  endtask

  // Output monitor: mid-cycle sampling, scoreboard compare, stall stability.
  initial begin
    logic [36:0] held;
    logic [36:0] cur;
    logic [36:0] e;
    bit stall;
    stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        stall = 1'b0;
      end else begin
        cur = {last_out, keep_out, data_out};
        if (stall) chk_val("stable", {valid_out, cur}, {1'b1, held});
        if (valid_out && ready_out) begin
          if (exp_q.size() == 0) chk_val("spurious", valid_out, 1'b0);
          else begin
            e = exp_q.pop_front();
            chk_val("beat", cur, e);
          end
        end
        stall = valid_out && !ready_out;
        held = cur;
      end
    end
  end

  // ready_out: always 1, or 50% random when backpressure is enabled.
  initial forever begin
    @(posedge clk);
    #1;
    ready_out = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  task automatic send_hdr(input int h, input logic [31:0] hdr, input logic [7:0] pl[$], input bit model);
    int cnt;
    valid_insert = 1'b1;
    data_insert = hdr;
    hdr_bytes = CW'(h);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (ready_insert) break;
      cnt++;
      if (cnt > 500) begin
        chk_val("hdr_timeout", ready_insert, 1'b1);
        break;
      end
    end
    chk_val("hdr_after_last", exp_q.size(), 0);
    chk_val("rdy_in_idle", ready_in, 1'b0);
    if (model) model_pkt(h, hdr, pl);
    else while (dir_q.size() > 0) exp_q.push_back(dir_q.pop_front());
    @(posedge clk);
    #1;
    valid_insert = 1'b0;
    data_insert = $urandom;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input bit lat_chk);
    int cnt;
    valid_in = 1'b1;
    data_in = d;
    keep_in = k;
    last_in = l;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (ready_in) break;
      cnt++;
      if (cnt > 500) begin
        chk_val("in_timeout", ready_in, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    data_in = $urandom;
    keep_in = '0;
    last_in = 1'b0;
    if (lat_chk) begin
      @(negedge clk);
      chk_val("latency", valid_out, 1'b1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input int h, input logic [31:0] hdr, input logic [7:0] pl[$],
                          input bit model, input bit lat_chk, input int gap);
    logic [31:0] d;
    logic [3:0] k;
    send_hdr(h, hdr, pl, model);
    for (int b = 0; b < pl.size(); b += NB) begin
      if (gap > 0 && $urandom_range(0, 99) < gap) begin
        @(posedge clk);
        #1;
      end
      d = $urandom;
      k = '0;
      for (int j = 0; j < NB; j++) begin
        if (b + j < pl.size()) begin
          d[8*(NB-1-j) +: 8] = pl[b+j];
          k[NB-1-j] = 1'b1;
        end
      end
      send_beat(d, k, (b + NB >= pl.size()), lat_chk);
    end
  endtask

  initial begin
    logic [7:0] pl[$];
    int cnt;
    int len;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_val("rst_valid_out", valid_out, 1'b0);
    chk_val("rst_data_out", data_out, 32'h0);
    chk_val("rst_keep_out", keep_out, 4'h0);
    chk_val("rst_last_out", last_out, 1'b0);
    chk_val("rst_ready_in", ready_in, 1'b0);
    chk_val("rst_ready_insert", ready_insert, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_val("ready_insert_after_rst", ready_insert, 1'b1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // two-beat packet, H=2, with flush
    dir_q.push_back({1'b0, 4'hF, 32'hAABB1122});
    dir_q.push_back({1'b0, 4'hF, 32'h33445566});
    dir_q.push_back({1'b1, 4'hC, 32'h77880000});
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt(2, 32'h0000AABB, pl, 1'b0, 1'b1, 0);

    // pass-through, H=0
    dir_q.push_back({1'b0, 4'hF, 32'h01020304});
    dir_q.push_back({1'b1, 4'hC, 32'h05060000});
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(0, 32'h12345678, pl, 1'b0, 1'b1, 0);

    // full-width header, H=4
    dir_q.push_back({1'b0, 4'hF, 32'hDEADBEEF});
    dir_q.push_back({1'b1, 4'hC, 32'hCAFE0000});
    pl = '{8'hCA, 8'hFE};
    send_pkt(4, 32'hDEADBEEF, pl, 1'b0, 1'b1, 0);

    // tail fits, H=3, no flush; IDLE the cycle after the handshake
    dir_q.push_back({1'b1, 4'hF, 32'hA1A2A344});
    pl = '{8'h44};
    send_pkt(3, 32'h00A1A2A3, pl, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk_val("idle_after_tail", ready_insert, 1'b1);
    @(posedge clk);
    #1;

    // reset mid-packet
    mon_en = 1'b0;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_hdr(2, 32'h0000AABB, pl, 1'b0);
    send_beat(32'h11223344, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_val("mid_rst_valid_out", valid_out, 1'b0);
    chk_val("mid_rst_data_out", data_out, 32'h0);
    chk_val("mid_rst_keep_out", keep_out, 4'h0);
    chk_val("mid_rst_last_out", last_out, 1'b0);
    chk_val("mid_rst_ready_in", ready_in, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    chk_val("mid_rst_ready_insert", ready_insert, 1'b1);
    chk_val("mid_rst_no_stale", valid_out, 1'b0);
    @(posedge clk);
    #1;
    dir_q.push_back({1'b0, 4'hF, 32'h5A010203});
    dir_q.push_back({1'b1, 4'hC, 32'h04050000});
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pkt(1, 32'hFFFFFF5A, pl, 1'b0, 1'b1, 0);

    // random packets under 50% backpressure, including clamped header lengths
    bp_en = 1'b1;
    for (int p = 0; p < 200; p++) begin
      pl.delete();
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      send_pkt($urandom_range(0, 7), $urandom, pl, 1'b1, 1'b0, 30);
    end

    cnt = 0;
    while (exp_q.size() > 0 && cnt < 2000) begin
      @(posedge clk);
      cnt++;
    end
    chk_val("drain", exp_q.size(), 0);
    bp_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_val("end_idle", ready_insert, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
